node_path_sequencer: RTL and testbench

NODE_PATH_SEQUENCER -- requirements
Module: node_path_sequencer

---
 rtl/node_path_sequencer_if.sv | 26 ++
 rtl/node_path_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_node_path_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/node_path_sequencer_if.sv
// Bundle of plan, line-sensor and status signals shared between the path
// sequencer and whatever drives it.
interface node_path_sequencer_if;
   logic [2:0] turn;
   logic       plan_wr;
   logic [1:0] plan_data;
   logic       start;
   logic       abort;
   logic [2:0] motor_cmd;
   logic [3:0] node_count;
   logic [3:0] plan_level;
   logic       busy;
   logic       done;
   logic       fault;
   logic       overflow;

   modport master (
      output turn, plan_wr, plan_data, start, abort,
      input  motor_cmd, node_count, plan_level, busy, done, fault, overflow
   );

   modport slave (
      input  turn, plan_wr, plan_data, start, abort,
      output motor_cmd, node_count, plan_level, busy, done, fault, overflow
   );
endinterface

// File: rtl/node_path_sequencer.sv
// Line-following path sequencer: follows the line, confirms nodes, and at each
// node executes the next queued action from an 8-entry plan FIFO.
module node_path_sequencer #(
   parameter int NODE_DEBOUNCE = 4,
   parameter int TURN_MIN      = 16,
   parameter int TURN_MAX      = 1024,
   parameter int LOST_TIMEOUT  = 256,
   parameter int CROSS_CYCLES  = 32
) (
   input logic                  clk_50,
   input logic                  rst_n,
   node_path_sequencer_if.slave bus
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FOLLOW = 3'd1;
   localparam logic [2:0] S_NODE   = 3'd2;
   localparam logic [2:0] S_CROSS  = 3'd3;
   localparam logic [2:0] S_SPIN   = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;
   localparam logic [2:0] S_LOST   = 3'd6;

   localparam logic [2:0] M_STOP  = 3'b000;
   localparam logic [2:0] M_FWD   = 3'b001;
   localparam logic [2:0] M_LEFT  = 3'b010;
   localparam logic [2:0] M_RIGHT = 3'b011;
   localparam logic [2:0] T_NODE  = 3'b000;
   localparam logic [2:0] T_OFF   = 3'b100;

   localparam logic [1:0] A_STRAIGHT = 2'b00;
   localparam logic [1:0] A_LEFT     = 2'b01;
   localparam logic [1:0] A_HALT     = 2'b11;

   localparam int DEB_W   = $clog2(NODE_DEBOUNCE + 1);
   localparam int LOST_W  = $clog2(LOST_TIMEOUT + 1);
   localparam int SPIN_W  = $clog2(TURN_MAX + 1);
   localparam int CROSS_W = $clog2(CROSS_CYCLES + 1);

   localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(NODE_DEBOUNCE);
   localparam logic [LOST_W-1:0]  LOST_LAST  = LOST_W'(LOST_TIMEOUT);
   localparam logic [SPIN_W-1:0]  SPIN_MIN   = SPIN_W'(TURN_MIN);
   localparam logic [SPIN_W-1:0]  SPIN_LAST  = SPIN_W'(TURN_MAX);
   localparam logic [CROSS_W-1:0] CROSS_LAST = CROSS_W'(CROSS_CYCLES);

   logic [2:0]         state;
   logic [2:0]         motor;
   logic [3:0]         nodes;
   logic               fault_flag;
   logic               overflow_flag;
   logic [DEB_W-1:0]   deb_cnt;
   logic [LOST_W-1:0]  lost_cnt;
   logic [SPIN_W-1:0]  spin_cnt;
   logic [CROSS_W-1:0] cross_cnt;

   logic [1:0] fifo_mem [8];
   logic [2:0] wr_ptr;
   logic [2:0] rd_ptr;
   logic [3:0] level;
   logic       full;
   logic       empty;
   logic       pop;
   logic       push;
   logic [1:0] head;

   logic [DEB_W-1:0]   deb_next;
   logic [LOST_W-1:0]  lost_next;
   logic [SPIN_W-1:0]  spin_next;
   logic [CROSS_W-1:0] cross_next;

   assign full  = (level == 4'd8);
   assign empty = (level == 4'd0);
   assign head  = fifo_mem[rd_ptr];
   assign pop   = (state == S_NODE) && !empty;
   // A full FIFO still takes a push when the same cycle pops; abort drops it.
   assign push  = bus.plan_wr && !bus.abort && (!full || pop);

   assign deb_next   = deb_cnt + DEB_W'(1);
   assign lost_next  = lost_cnt + LOST_W'(1);
   assign spin_next  = spin_cnt + SPIN_W'(1);
   assign cross_next = cross_cnt + CROSS_W'(1);

   always_ff @(posedge clk_50) begin
      if (push) begin
         fifo_mem[wr_ptr] <= bus.plan_data;
      end
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr        <= 3'd0;
         rd_ptr        <= 3'd0;
         level         <= 4'd0;
         overflow_flag <= 1'b0;
      end else if (bus.abort) begin
         wr_ptr <= 3'd0;
         rd_ptr <= 3'd0;
         level  <= 4'd0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 3'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 3'd1;
         end
         level <= level + {3'b000, push} - {3'b000, pop};
         if (bus.plan_wr && full && !pop) begin
            overflow_flag <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         motor      <= M_STOP;
         nodes      <= 4'd0;
         fault_flag <= 1'b0;
         deb_cnt    <= '0;
         lost_cnt   <= '0;
         spin_cnt   <= '0;
         cross_cnt  <= '0;
      end else if (bus.abort) begin
         state     <= S_IDLE;
         motor     <= M_STOP;
         nodes     <= 4'd0;
         deb_cnt   <= '0;
         lost_cnt  <= '0;
         spin_cnt  <= '0;
         cross_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               motor <= M_STOP;
               if (bus.start) begin
                  state      <= S_FOLLOW;
                  nodes      <= 4'd0;
                  fault_flag <= 1'b0;
                  deb_cnt    <= '0;
                  lost_cnt   <= '0;
               end
            end
            S_FOLLOW: begin
               if (bus.turn == T_NODE) begin
                  motor    <= M_STOP;
                  lost_cnt <= '0;
                  if (deb_next == DEB_LAST) begin
                     deb_cnt <= '0;
                     state   <= S_NODE;
                  end else begin
                     deb_cnt <= deb_next;
                  end
               end else if (bus.turn == T_OFF) begin
                  deb_cnt <= '0;
                  if (lost_next == LOST_LAST) begin
                     lost_cnt   <= '0;
                     fault_flag <= 1'b1;
                     motor      <= M_STOP;
                     state      <= S_LOST;
                  end else begin
                     lost_cnt <= lost_next;
                  end
               end else begin
                  deb_cnt  <= '0;
                  lost_cnt <= '0;
                  if (bus.turn == M_FWD || bus.turn == M_LEFT || bus.turn == M_RIGHT) begin
                     motor <= bus.turn;
                  end
               end
            end
            S_NODE: begin
               if (nodes != 4'd15) begin
                  nodes <= nodes + 4'd1;
               end
               if (empty || head == A_HALT) begin
                  motor <= M_STOP;
                  state <= S_DONE;
               end else if (head == A_STRAIGHT) begin
                  motor     <= M_FWD;
                  cross_cnt <= '0;
                  state     <= S_CROSS;
               end else begin
                  motor    <= (head == A_LEFT) ? M_LEFT : M_RIGHT;
                  spin_cnt <= '0;
                  state    <= S_SPIN;
               end
            end
            S_CROSS: begin
               motor <= M_FWD;
               if (cross_next == CROSS_LAST) begin
                  cross_cnt <= '0;
                  state     <= S_FOLLOW;
               end else begin
                  cross_cnt <= cross_next;
               end
            end
            S_SPIN: begin
               // Line re-acquisition only counts once the minimum spin has elapsed.
               if (spin_next >= SPIN_MIN && bus.turn == M_FWD) begin
                  spin_cnt <= '0;
                  motor    <= M_FWD;
                  state    <= S_FOLLOW;
               end else if (spin_next == SPIN_LAST) begin
                  spin_cnt   <= '0;
                  fault_flag <= 1'b1;
                  motor      <= M_STOP;
                  state      <= S_LOST;
               end else begin
                  spin_cnt <= spin_next;
               end
            end
            S_DONE: begin
               motor <= M_STOP;
               state <= S_IDLE;
            end
            S_LOST: begin
               motor <= M_STOP;
            end
            default: begin
               motor <= M_STOP;
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.motor_cmd  = motor;
   assign bus.node_count = nodes;
   assign bus.plan_level = level;
   assign bus.busy       = (state != S_IDLE) && (state != S_DONE);
   assign bus.done       = (state == S_DONE);
   assign bus.fault      = fault_flag;
   assign bus.overflow   = overflow_flag;

endmodule

// File: tb/tb_node_path_sequencer.sv
// Directed bench for node_path_sequencer: stimulus queues expected values,
// a negedge monitor pops and compares them, and a done watcher checks each run end.
module tb_node_path_sequencer;

   localparam int SEL_MOTOR = 0;
   localparam int SEL_NODES = 1;
   localparam int SEL_LEVEL = 2;
   localparam int SEL_BUSY  = 3;
   localparam int SEL_DONE  = 4;
   localparam int SEL_FAULT = 5;
   localparam int SEL_OVF   = 6;

   logic clk_50 = 1'b0;
   logic rst_n;

   int checks   = 0;
   int failures = 0;

   string      name_q[$];
   int         sel_q[$];
   logic [3:0] val_q[$];
   logic [3:0] done_q[$];

   node_path_sequencer_if bus ();

   node_path_sequencer #(
      .NODE_DEBOUNCE(4),
      .TURN_MIN(16),
      .TURN_MAX(1024),
      .LOST_TIMEOUT(256),
      .CROSS_CYCLES(32)
   ) dut (
      .clk_50(clk_50),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk_50 = ~clk_50;

   function automatic logic [3:0] field(input int sel);
      case (sel)
         SEL_MOTOR: return {1'b0, bus.motor_cmd};
         SEL_NODES: return bus.node_count;
         SEL_LEVEL: return bus.plan_level;
         SEL_BUSY:  return {3'b000, bus.busy};
         SEL_DONE:  return {3'b000, bus.done};
         SEL_FAULT: return {3'b000, bus.fault};
         SEL_OVF:   return {3'b000, bus.overflow};
         default:   return 4'hF;
      endcase
   endfunction

   // Monitor: compares queued expectations and every done pulse at the negedge.
   always @(negedge clk_50) begin : monitor
      string      nm;
      int         sl;
      logic [3:0] ev;
      logic [3:0] av;
      while (name_q.size() > 0) begin
         nm = name_q.pop_front();
         sl = sel_q.pop_front();
         ev = val_q.pop_front();
         av = field(sl);
         checks++;
         if (av !== ev) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", nm, av, ev, $time);
         end
      end
      if (bus.done === 1'b1) begin
         checks++;
         if (done_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_done actual=1 expected=0 at %0t", $time);
         end else begin
            ev = done_q.pop_front();
            if (bus.node_count !== ev) begin
               failures++;
               $display("[TB] FAIL done_node_count actual=%0d expected=%0d", bus.node_count, ev);
            end
            checks++;
            if (bus.motor_cmd !== 3'b000) begin
               failures++;
               $display("[TB] FAIL done_motor actual=%0d expected=0", bus.motor_cmd);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_50);
      #1;
   endtask

   task automatic applyStimulus(input logic [2:0] t, input logic wr, input logic [1:0] data,
                                input logic st, input logic ab, input int n);
      bus.turn      = t;
      bus.plan_wr   = wr;
      bus.plan_data = data;
      bus.start     = st;
      bus.abort     = ab;
      repeat (n) tick();
      bus.plan_wr = 1'b0;
      bus.start   = 1'b0;
      bus.abort   = 1'b0;
   endtask

   task automatic checkOutput(input string name, input int sel, input logic [3:0] value);
      name_q.push_back(name);
      sel_q.push_back(sel);
      val_q.push_back(value);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_motor"}, SEL_MOTOR, 4'd0);
      checkOutput({tag, "_nodes"}, SEL_NODES, 4'd0);
      checkOutput({tag, "_level"}, SEL_LEVEL, 4'd0);
      checkOutput({tag, "_busy"},  SEL_BUSY,  4'd0);
      checkOutput({tag, "_done"},  SEL_DONE,  4'd0);
      checkOutput({tag, "_fault"}, SEL_FAULT, 4'd0);
      checkOutput({tag, "_ovf"},   SEL_OVF,   4'd0);
   endtask

   initial begin : stimulus
      logic [1:0] plan_vec [9];
      plan_vec = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
      bus.turn = 3'b000;
      bus.plan_wr = 1'b0;
      bus.plan_data = 2'b00;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      rst_n = 1'b0;
      repeat (3) tick();
      checkResetValues("reset");
      tick();
      rst_n = 1'b1;

      // Three-node run: left, right, halt.
      applyStimulus(3'b000, 1'b1, 2'b01, 1'b0, 1'b0, 1);
      applyStimulus(3'b000, 1'b1, 2'b10, 1'b0, 1'b0, 1);
      applyStimulus(3'b000, 1'b1, 2'b11, 1'b0, 1'b0, 1);
      checkOutput("push3_level", SEL_LEVEL, 4'd3);
      checkOutput("idle_busy", SEL_BUSY, 4'd0);
      applyStimulus(3'b000, 1'b0, 2'b00, 1'b1, 1'b0, 1);
      checkOutput("start_busy", SEL_BUSY, 4'd1);
      checkOutput("start_motor", SEL_MOTOR, 4'd0);
      applyStimulus(3'b001, 1'b0, 2'b00, 1'b0, 1'b0, 1);
      checkOutput("follow_fwd", SEL_MOTOR, 4'd1);
      applyStimulus(3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 4);
      checkOutput("debounce_motor", SEL_MOTOR, 4'd0);
      checkOutput("debounce_nodes", SEL_NODES, 4'd0);
      applyStimulus(3'b100, 1'b0, 2'b00, 1'b0, 1'b0, 1);
      checkOutput("node1_spin_left", SEL_MOTOR, 4'd2);
      checkOutput("node1_count", SEL_NODES, 4'd1);
      checkOutput("node1_level", SEL_LEVEL, 4'd2);
      applyStimulus(3'b100, 1'b0, 2'b00, 1'b0, 1'b0, 19);
      checkOutput("spin1_hold", SEL_MOTOR, 4'd2);
      applyStimulus(3'b001, 1'b0, 2'b00, 1'b0, 1'b0, 1);
      checkOutput("spin1_exit", SEL_MOTOR, 4'd1);
      checkOutput("spin1_level", SEL_LEVEL, 4'd2);

      // Three-cycle glitch must not be taken as a node.
      applyStimulus(3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 3);
      checkOutput("glitch_motor_stop", SEL_MOTOR, 4'd0);
      applyStimulus(3'b001, 1'b0, 2'b00, 1'b0, 1'b0, 1);
      checkOutput("glitch_motor", SEL_MOTOR, 4'd1);
      checkOutput("glitch_nodes", SEL_NODES, 4'd1);
      checkOutput("glitch_busy", SEL_BUSY, 4'd1);

      applyStimulus(3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 4);
      applyStimulus(3'b001, 1'b0, 2'b00, 1'b0, 1'b0, 1);
      checkOutput("node2_spin_right", SEL_MOTOR, 4'd3);
      checkOutput("node2_count", SEL_NODES, 4'd2);
      checkOutput("node2_level", SEL_LEVEL, 4'd1);
      applyStimulus(3'b001, 1'b0, 2'b00, 1'b0, 1'b0, 15);
      checkOutput("spin2_min_hold", SEL_MOTOR, 4'd3);
      applyStimulus(3'b001, 1'b0, 2'b00, 1'b0, 1'b0, 1);
      checkOutput("spin2_exit", SEL_MOTOR, 4'd1);

      applyStimulus(3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 4);
      done_q.push_back(4'd3);
      applyStimulus(3'b001, 1'b0, 2'b00, 1'b0, 1'b0, 1);
      checkOutput("node3_done", SEL_DONE, 4'd1);
      checkOutput("node3_busy", SEL_BUSY, 4'd0);
      checkOutput("node3_level", SEL_LEVEL, 4'd0);
      applyStimulus(3'b001, 1'b0, 2'b00, 1'b0, 1'b0, 1);
      checkOutput("after_done_pulse", SEL_DONE, 4'd0);
      checkOutput("after_done_busy", SEL_BUSY, 4'd0);

      // Lost timeout with held steering code.
      applyStimulus(3'b001, 1'b0, 2'b00, 1'b1, 1'b0, 1);
      checkOutput("run2_nodes_cleared", SEL_NODES, 4'd0);
      applyStimulus(3'b011, 1'b0, 2'b00, 1'b0, 1'b0, 1);
      checkOutput("follow_right", SEL_MOTOR, 4'd3);
      applyStimulus(3'b100, 1'b0, 2'b00, 1'b0, 1'b0, 255);
      checkOutput("lost_hold_motor", SEL_MOTOR, 4'd3);
      checkOutput("lost_pre_fault", SEL_FAULT, 4'd0);
      applyStimulus(3'b100, 1'b0, 2'b00, 1'b0, 1'b0, 1);
      checkOutput("lost_fault", SEL_FAULT, 4'd1);
      checkOutput("lost_motor", SEL_MOTOR, 4'd0);
      checkOutput("lost_busy", SEL_BUSY, 4'd1);
      applyStimulus(3'b001, 1'b0, 2'b00, 1'b1, 1'b0, 3);
      checkOutput("lost_ignores_start", SEL_BUSY, 4'd1);
      checkOutput("lost_sticky_fault", SEL_FAULT, 4'd1);
      checkOutput("lost_stays_stopped", SEL_MOTOR, 4'd0);
      applyStimulus(3'b001, 1'b1, 2'b01, 1'b0, 1'b0, 1);
      applyStimulus(3'b001, 1'b1, 2'b10, 1'b0, 1'b0, 1);
      checkOutput("lost_push_level", SEL_LEVEL, 4'd2);
      applyStimulus(3'b001, 1'b1, 2'b11, 1'b0, 1'b1, 1);
      checkOutput("abort_level", SEL_LEVEL, 4'd0);
      checkOutput("abort_busy", SEL_BUSY, 4'd0);
      checkOutput("abort_motor", SEL_MOTOR, 4'd0);
      checkOutput("abort_push_no_ovf", SEL_OVF, 4'd0);

      // Fill past capacity, then push and pop together at a node.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(3'b001, 1'b1, plan_vec[i], 1'b0, 1'b0, 1);
      end
      checkOutput("fill8_level", SEL_LEVEL, 4'd8);
      checkOutput("fill8_ovf", SEL_OVF, 4'd0);
      applyStimulus(3'b001, 1'b1, plan_vec[8], 1'b0, 1'b0, 1);
      checkOutput("fill9_level", SEL_LEVEL, 4'd8);
      checkOutput("fill9_ovf", SEL_OVF, 4'd1);
      applyStimulus(3'b001, 1'b0, 2'b00, 1'b1, 1'b0, 1);
      applyStimulus(3'b001, 1'b0, 2'b00, 1'b0, 1'b0, 1);
      applyStimulus(3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 4);
      applyStimulus(3'b010, 1'b1, 2'b11, 1'b0, 1'b0, 1);
      checkOutput("full_pushpop_level", SEL_LEVEL, 4'd8);
      checkOutput("cross_motor", SEL_MOTOR, 4'd1);
      checkOutput("cross_nodes", SEL_NODES, 4'd1);
      applyStimulus(3'b010, 1'b0, 2'b00, 1'b0, 1'b0, 31);
      checkOutput("cross_31", SEL_MOTOR, 4'd1);
      applyStimulus(3'b010, 1'b0, 2'b00, 1'b0, 1'b0, 1);
      checkOutput("cross_32", SEL_MOTOR, 4'd1);
      applyStimulus(3'b010, 1'b0, 2'b00, 1'b0, 1'b0, 1);
      checkOutput("cross_follow_left", SEL_MOTOR, 4'd2);
      applyStimulus(3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 4);
      applyStimulus(3'b100, 1'b0, 2'b00, 1'b0, 1'b0, 1);
      checkOutput("fifo_order_spin_left", SEL_MOTOR, 4'd2);
      checkOutput("fifo_order_level", SEL_LEVEL, 4'd7);
      checkOutput("fifo_order_nodes", SEL_NODES, 4'd2);
      applyStimulus(3'b100, 1'b0, 2'b00, 1'b0, 1'b1, 1);
      checkOutput("abort2_level", SEL_LEVEL, 4'd0);
      checkOutput("abort2_nodes", SEL_NODES, 4'd0);
      checkOutput("abort2_busy", SEL_BUSY, 4'd0);

      // Empty plan: the run ends at the first node.
      applyStimulus(3'b001, 1'b0, 2'b00, 1'b1, 1'b0, 1);
      checkOutput("empty_run_busy", SEL_BUSY, 4'd1);
      applyStimulus(3'b001, 1'b0, 2'b00, 1'b0, 1'b0, 1);
      applyStimulus(3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 4);
      done_q.push_back(4'd1);
      applyStimulus(3'b001, 1'b0, 2'b00, 1'b0, 1'b0, 1);
      checkOutput("empty_run_done", SEL_DONE, 4'd1);
      applyStimulus(3'b001, 1'b0, 2'b00, 1'b0, 1'b0, 1);

      // Reset dropped mid-spin must clear everything before the next edge.
      applyStimulus(3'b001, 1'b1, 2'b01, 1'b0, 1'b0, 1);
      applyStimulus(3'b001, 1'b0, 2'b00, 1'b1, 1'b0, 1);
      applyStimulus(3'b001, 1'b0, 2'b00, 1'b0, 1'b0, 1);
      applyStimulus(3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 4);
      applyStimulus(3'b100, 1'b0, 2'b00, 1'b0, 1'b0, 1);
      checkOutput("pre_reset_spin", SEL_MOTOR, 4'd2);
      applyStimulus(3'b100, 1'b0, 2'b00, 1'b0, 1'b0, 5);
      #1;
      rst_n = 1'b0;
      checkResetValues("async_reset");
      tick();
      tick();
      rst_n = 1'b1;
      repeat (3) tick();

      checks++;
      if (done_q.size() != 0 || name_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL pending_expectations actual=%0d expected=0", done_q.size() + name_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
